memref_rd_stream: RTL and testbench

- Read sequencer that sits directly upstream and downstream of a memref_rd port.
- On a start pulse it issues a burst of sequential reads (`rd_en`/`addr`) to the memref_rd port.
- It captures the returned `dout`/`dout_valid` into a small FIFO and presents the words as a valid/ready stream with a last marker.
- It converts the fixed-latency, no-backpressure read port into a backpressurable stream for testbench consumers and kernel wrappers.

---
 rtl/memref_rd_stream_if.sv | 27 ++
 rtl/memref_rd_stream.sv | 176 +++++++++++++++++
 tb/tb_memref_rd_stream.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memref_rd_stream_if.sv
// rtl/memref_rd_stream_if.sv - memref_rd read port plus output word stream of memref_rd_stream
// master: the sequencer; slave: the memory port / stream consumer side.
interface memref_rd_stream_if #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 8
);
    localparam int AW = $clog2(SIZE);

    logic             rd_en;
    logic [AW-1:0]    addr;
    logic             dout_valid;
    logic [WIDTH-1:0] dout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (
        output rd_en, addr, out_valid, out_data, out_last,
        input  dout_valid, dout, out_ready
    );

    modport slave (
        input  rd_en, addr, out_valid, out_data, out_last,
        output dout_valid, dout, out_ready
    );
endinterface

// File: rtl/memref_rd_stream.sv
// rtl/memref_rd_stream.sv - burst read sequencer turning a fixed-latency memref_rd port into a valid/ready stream
// Optional protocol checking (sticky err) is built when MEMREF_RD_STREAM_CHECK_EN is defined.
module memref_rd_stream #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          err,
    memref_rd_stream_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] ADDR_ONE = 1;
    localparam logic [CW-1:0] OCC_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [AW:0]      count_q;
    logic [AW:0]      issued_q;
    logic [AW:0]      pushed_q;
    logic [AW-1:0]    addr_q;
    logic             inflight_q;
    logic             rd_en;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] last_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    occ_q;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             start_ok;

    assign empty    = (occ_q == '0);
    assign full     = (occ_q == CW'(DEPTH));
    assign start_ok = (state_q == S_IDLE) && start;
    assign pop      = bus.out_valid && bus.out_ready;
    // Data with no outstanding request (e.g. issued before a reset) is dropped.
    assign push     = bus.dout_valid && inflight_q && (!full || pop);

    assign bus.rd_en     = rd_en;
    assign bus.addr      = addr_q;
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.out_last  = !empty && last_q[rd_ptr_q];
    assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Reserve a slot for the read in flight so the FIFO cannot overflow.
                if ((occ_q + {{(CW-1){1'b0}}, inflight_q}) < CW'(DEPTH)) begin
                    rd_en = 1'b1;
                    if ((issued_q + CNT_ONE) == count_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The final word leaving implies an empty FIFO and nothing in flight.
                if (pop && bus.out_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            issued_q   <= '0;
            pushed_q   <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_en;
            if (start_ok) begin
                count_q  <= count;
                addr_q   <= base_addr;
                issued_q <= '0;
                pushed_q <= '0;
            end else begin
                if (rd_en) begin
                    issued_q <= issued_q + CNT_ONE;
                    addr_q   <= (addr_q == AW'(SIZE - 1)) ? '0 : addr_q + ADDR_ONE;
                end
                if (push) begin
                    pushed_q <= pushed_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q]  <= bus.dout;
                last_q[wr_ptr_q] <= ((pushed_q + CNT_ONE) == count_q);
                wr_ptr_q         <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_ONE;
                2'b01:   occ_q <= occ_q - OCC_ONE;
                default: occ_q <= occ_q;
            endcase
        end
    end

`ifdef MEMREF_RD_STREAM_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            if (bus.dout_valid && !inflight_q) begin
                err_q <= 1'b1;
                $error("memref_rd_stream: dout_valid with no read in flight");
            end
            if (bus.dout_valid && full && !pop) begin
                err_q <= 1'b1;
                $error("memref_rd_stream: push into full FIFO");
            end
            if (start && busy) begin
                err_q <= 1'b1;
                $error("memref_rd_stream: start while busy");
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_memref_rd_stream.sv
// tb/tb_memref_rd_stream.sv - self-checking bench: burst model scoreboard plus directed scenarios
module tb_memref_rd_stream;
    localparam int WIDTH = 32;
    localparam int SIZE  = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] base_addr = '0;
    logic [3:0] count = '0;
    logic       busy;
    logic       done;
    logic       err;
    logic       force_dv = 1'b0;

    memref_rd_stream_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus_if ();

    memref_rd_stream #(.WIDTH(WIDTH), .SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memref_rd: one-cycle latency, no backpressure
    logic [31:0] mem_arr [SIZE];
    always @(posedge clk) begin
        bus_if.dout_valid <= bus_if.rd_en | force_dv;
        bus_if.dout       <= mem_arr[bus_if.addr];
    end

    int n_chk = 0;
    int n_fail = 0;

    int exp_data[$];
    int exp_addr[$];
    int issued = 0;
    int accepted = 0;

    int log_data[$];
    int log_last[$];
    int log_cyc[$];
    int log_addr[$];
    int rd_cnt = 0;
    int done_cyc = 0;
    int s_cyc = 0;
    bit done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_if.rd_en) begin
                rd_cnt++;
                log_addr.push_back(int'(bus_if.addr));
                issued++;
                if (exp_addr.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_en_extra: got rd_en=1 addr=%0d expected no request", bus_if.addr);
                end else begin
                    chk("rd_addr", 32'(bus_if.addr), exp_addr.pop_front());
                end
                chk("outstanding_le_depth", 32'(issued - accepted <= DEPTH), 1);
            end
            if (bus_if.out_valid) begin
                if (exp_data.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL out_valid_extra: got out_data=%0d expected out_valid=0", bus_if.out_data);
                end else begin
                    chk("out_data", bus_if.out_data, exp_data[0]);
                    chk("out_last", 32'(bus_if.out_last), 32'(exp_data.size() == 1));
                    if (bus_if.out_ready) begin
                        log_data.push_back(int'(bus_if.out_data));
                        log_last.push_back(int'(bus_if.out_last));
                        log_cyc.push_back(cyc);
                        void'(exp_data.pop_front());
                        accepted++;
                    end
                end
            end
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                chk("busy_low_at_done", 32'(busy), 0);
            end
`ifndef MEMREF_RD_STREAM_CHECK_EN
            chk("err_tied_low", 32'(err), 0);
`endif
        end
    end

    task automatic clear_logs();
        log_data.delete();
        log_last.delete();
        log_cyc.delete();
        log_addr.delete();
        rd_cnt    = 0;
        done_seen = 0;
        issued    = 0;
        accepted  = 0;
    endtask

    task automatic start_burst(input int b, input int c);
        for (int i = 0; i < c; i++) begin
            exp_data.push_back(10 + ((b + i) % SIZE));
            exp_addr.push_back((b + i) % SIZE);
        end
        base_addr = 3'(b);
        count     = 4'(c);
        start     = 1'b1;
        s_cyc     = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && !done_seen; k++) @(posedge clk);
        chk("done_within_budget", 32'(done_seen), 1);
        #1;
        chk("model_drained", 32'(exp_data.size()), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd_en"}, 32'(bus_if.rd_en), 0);
        chk({tag, "_out_valid"}, 32'(bus_if.out_valid), 0);
        chk({tag, "_out_last"}, 32'(bus_if.out_last), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_addr"}, 32'(bus_if.addr), 0);
        chk({tag, "_out_data"}, bus_if.out_data, 0);
    endtask

    int t2_addr [4] = '{6, 7, 0, 1};
    int t2_data [4] = '{16, 17, 10, 11};

    initial begin
        for (int i = 0; i < SIZE; i++) mem_arr[i] = 32'(10 + i);
        bus_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // full burst, consumer always ready
        clear_logs();
        start_burst(0, 8);
        wait_done(40);
        chk("t1_done_latency", 32'(done_cyc - s_cyc), 11);
        chk("t1_words", 32'(log_data.size()), 8);
        for (int i = 0; i < log_data.size(); i++) chk("t1_data", 32'(log_data[i]), 32'(10 + i));
        if (log_data.size() == 8) begin
            chk("t1_first_word_cycle", 32'(log_cyc[0] - s_cyc), 3);
            chk("t1_back_to_back", 32'(log_cyc[7] - log_cyc[0]), 7);
            chk("t1_last_on_17", 32'(log_last[7]), 1);
            chk("t1_no_last_on_16", 32'(log_last[6]), 0);
        end

        // address wrap
        clear_logs();
        start_burst(6, 4);
        wait_done(40);
        chk("t2_reads", 32'(log_addr.size()), 4);
        for (int i = 0; i < log_addr.size() && i < 4; i++) chk("t2_addr", 32'(log_addr[i]), 32'(t2_addr[i]));
        chk("t2_words", 32'(log_data.size()), 4);
        for (int i = 0; i < log_data.size() && i < 4; i++) chk("t2_data", 32'(log_data[i]), 32'(t2_data[i]));
        if (log_last.size() == 4) chk("t2_last_on_11", 32'(log_last[3]), 1);

        // backpressure: stall after DEPTH requests
        clear_logs();
        bus_if.out_ready = 1'b0;
        start_burst(0, 8);
        repeat (9) @(posedge clk);
        #1;
        chk("t3_reads_before_stall", 32'(rd_cnt), 4);
        bus_if.out_ready = 1'b1;
        wait_done(60);
        chk("t3_words", 32'(log_data.size()), 8);
        for (int i = 0; i < log_data.size(); i++) chk("t3_data", 32'(log_data[i]), 32'(10 + i));
        chk("t3_total_reads", 32'(rd_cnt), 8);

        // empty burst
        clear_logs();
        start_burst(3, 0);
        wait_done(10);
        chk("t4_done_latency", 32'(done_cyc - s_cyc), 1);
        chk("t4_no_reads", 32'(rd_cnt), 0);
        chk("t4_no_words", 32'(log_data.size()), 0);

        // asynchronous reset mid-burst, then a fresh burst
        clear_logs();
        start_burst(0, 8);
        for (int k = 0; k < 40 && log_data.size() < 3; k++) @(negedge clk);
        chk("t5_three_words_before_reset", 32'(log_data.size()), 3);
        #2;
        rst = 1'b1;
        exp_data.delete();
        exp_addr.delete();
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        start_burst(2, 2);
        wait_done(20);
        chk("t5_words", 32'(log_data.size()), 2);
        if (log_data.size() == 2) begin
            chk("t5_word0", 32'(log_data[0]), 12);
            chk("t5_word1", 32'(log_data[1]), 13);
            chk("t5_last", 32'(log_last[1]), 1);
        end

        // stray read data with nothing in flight
        clear_logs();
        @(posedge clk);
        #1;
        force_dv = 1'b1;
        @(posedge clk);
        #1;
        force_dv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`ifdef MEMREF_RD_STREAM_CHECK_EN
        chk("t6_err_sticky", 32'(err), 1);
`else
        chk("t6_err_disabled", 32'(err), 0);
`endif
        chk("t6_stray_dropped", 32'(bus_if.out_valid), 0);
        rst = 1'b1;
        #1;
        chk("t6_err_cleared_by_rst", 32'(err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
